driver_cmd_issuer: RTL and testbench

- Host-side command issuer that generates the slow-clock signal set consumed by the dot driver core: pattern-memory writes, row/column select, inverter select, and output-active firing.
- Runs on the host clock. The receiving core resynchronises every signal through per-bit synchronisers, so this block holds each field stable around every strobe for programmable setup/strobe/hold windows.
- Accepts commands over a valid/ready interface from the management/bus logic.

---
 rtl/driver_cmd_issuer.sv | 138 +++++++++++++
 tb/tb_driver_cmd_issuer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/driver_cmd_issuer.sv
// rtl/driver_cmd_issuer.sv - host-side command issuer producing timed strobe/select/fire signals for the dot driver core
module driver_cmd_issuer #(
  parameter int MEM_ADDRESS_LENGTH = 6,
  parameter int SETUP_CYCLES       = 2,
  parameter int STROBE_CYCLES      = 4,
  parameter int HOLD_CYCLES        = 2,
  parameter int CNT_WIDTH          = 16
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [1:0]                    cmd_op,
  input  logic [9:0]                    cmd_addr,
  input  logic [15:0]                   cmd_data,
  input  logic                          fire_abort,
  output logic [9:0]                    mem_address_a,
  output logic                          mem_write_n_a,
  output logic [MEM_ADDRESS_LENGTH-1:0] row_select_a,
  output logic [MEM_ADDRESS_LENGTH-1:0] col_select_a,
  output logic [15:0]                   data_in_a,
  output logic                          row_col_select_a,
  output logic                          output_active_a,
  output logic                          inverter_select_a,
  output logic                          busy,
  output logic                          fire_done
);

  localparam logic [1:0] OP_WRITE  = 2'd0;
  localparam logic [1:0] OP_SELECT = 2'd1;
  localparam logic [1:0] OP_FIRE   = 2'd2;

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, FIRE} state_t;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 done_d;
  logic                 accept;

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign accept    = cmd_valid && (state_q == IDLE);

  // The counter holds the remaining cycles minus one for the current phase.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          case (cmd_op)
            OP_WRITE: begin
              state_d = SETUP;
              cnt_d   = CNT_WIDTH'(SETUP_CYCLES - 1);
            end
            OP_SELECT: begin
              state_d = HOLD;
              cnt_d   = CNT_WIDTH'(HOLD_CYCLES - 1);
            end
            OP_FIRE: begin
              if (cmd_data == 16'd0) begin
                done_d = 1'b1;
              end else begin
                state_d = FIRE;
                cnt_d   = CNT_WIDTH'(cmd_data - 16'd1);
              end
            end
            default: ;
          endcase
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          state_d = STROBE;
          cnt_d   = CNT_WIDTH'(STROBE_CYCLES - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      STROBE: begin
        if (cnt_q == '0) begin
          state_d = HOLD;
          cnt_d   = CNT_WIDTH'(HOLD_CYCLES - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      HOLD: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d = cnt_q - 1'b1;
      end
      FIRE: begin
        // Abort and natural expiry share one exit so a coincident abort yields a single done.
        if (fire_abort || cnt_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q           <= IDLE;
      cnt_q             <= '0;
      mem_address_a     <= '0;
      data_in_a         <= '0;
      row_select_a      <= '0;
      col_select_a      <= '0;
      row_col_select_a  <= 1'b0;
      inverter_select_a <= 1'b0;
      mem_write_n_a     <= 1'b1;
      output_active_a   <= 1'b0;
      fire_done         <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      mem_write_n_a   <= (state_d != STROBE);
      output_active_a <= (state_d == FIRE);
      fire_done       <= done_d;
      if (accept && cmd_op == OP_WRITE) begin
        mem_address_a <= cmd_addr;
        data_in_a     <= cmd_data;
      end
      if (accept && cmd_op == OP_SELECT) begin
        row_select_a      <= MEM_ADDRESS_LENGTH'(cmd_data[5:0]);
        col_select_a      <= MEM_ADDRESS_LENGTH'(cmd_data[11:6]);
        row_col_select_a  <= cmd_data[12];
        inverter_select_a <= cmd_data[13];
      end
    end
  end

endmodule

// File: tb/tb_driver_cmd_issuer.sv
// tb/tb_driver_cmd_issuer.sv - directed self-checking bench for driver_cmd_issuer
module tb_driver_cmd_issuer;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [9:0]  cmd_addr;
  logic [15:0] cmd_data;
  logic        fire_abort;
  logic [9:0]  mem_address_a;
  logic        mem_write_n_a;
  logic [5:0]  row_select_a;
  logic [5:0]  col_select_a;
  logic [15:0] data_in_a;
  logic        row_col_select_a;
  logic        output_active_a;
  logic        inverter_select_a;
  logic        busy;
  logic        fire_done;

  int errors = 0;
  int checks = 0;

  driver_cmd_issuer dut (
    .clock(clock), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .fire_abort(fire_abort),
    .mem_address_a(mem_address_a), .mem_write_n_a(mem_write_n_a),
    .row_select_a(row_select_a), .col_select_a(col_select_a),
    .data_in_a(data_in_a), .row_col_select_a(row_col_select_a),
    .output_active_a(output_active_a), .inverter_select_a(inverter_select_a),
    .busy(busy), .fire_done(fire_done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [9:0] addr, input logic [15:0] data);
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_data  = data;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
  endtask

  // Field stability ahead of each strobe and strobe/fire exclusion, observed every cycle.
  logic [25:0] prev_fields;
  logic        prev_wn;
  int          stable;
  always @(negedge clock) begin
    if (!reset_n) begin
      stable  = 0;
      prev_wn = 1'b1;
    end else begin
      if ({mem_address_a, data_in_a} == prev_fields) stable++;
      else stable = 1;
      if (prev_wn && !mem_write_n_a) chk("setup_stable", 32'(stable >= 3), 32'd1);
      chk("no_overlap", 32'(!mem_write_n_a && output_active_a), 32'd0);
      prev_wn = mem_write_n_a;
    end
    prev_fields = {mem_address_a, data_in_a};
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

  initial begin
    int accept_cyc[3];
    int idx;
    int cyc;
    reset_n    = 1'b0;
    cmd_valid  = 1'b0;
    cmd_op     = 2'd3;
    cmd_addr   = '0;
    cmd_data   = '0;
    fire_abort = 1'b0;
    step();
    step();
    chk("rst_wn", 32'(mem_write_n_a), 32'd1);
    chk("rst_active", 32'(output_active_a), 32'd0);
    chk("rst_addr", 32'(mem_address_a), 32'd0);
    chk("rst_data", 32'(data_in_a), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(fire_done), 32'd0);
    reset_n = 1'b1;
    step();
    chk("rst_ready", 32'(cmd_ready), 32'd1);

    // WRITE 0x2A5 / 0xBEEF
    issue(2'd0, 10'h2A5, 16'hBEEF);
    chk("wr_addr_t1", 32'(mem_address_a), 32'h2A5);
    chk("wr_data_t1", 32'(data_in_a), 32'hBEEF);
    chk("wr_ready_t1", 32'(cmd_ready), 32'd0);
    for (int k = 1; k <= 8; k++) begin
      chk("wr_wn", 32'(mem_write_n_a), (k >= 3 && k <= 6) ? 32'd0 : 32'd1);
      chk("wr_busy", 32'(busy), 32'd1);
      chk("wr_addr_hold", 32'(mem_address_a), 32'h2A5);
      chk("wr_data_hold", 32'(data_in_a), 32'hBEEF);
      step();
    end
    chk("wr_ready_t9", 32'(cmd_ready), 32'd1);
    chk("wr_busy_t9", 32'(busy), 32'd0);

    // SELECT 0x2843
    issue(2'd1, 10'h000, 16'h2843);
    chk("sel_row", 32'(row_select_a), 32'd3);
    chk("sel_col", 32'(col_select_a), 32'd33);
    chk("sel_rcs", 32'(row_col_select_a), 32'd0);
    chk("sel_inv", 32'(inverter_select_a), 32'd1);
    chk("sel_busy_t1", 32'(busy), 32'd1);
    chk("sel_wn_t1", 32'(mem_write_n_a), 32'd1);
    chk("sel_addr_kept", 32'(mem_address_a), 32'h2A5);
    step();
    chk("sel_busy_t2", 32'(busy), 32'd1);
    chk("sel_wn_t2", 32'(mem_write_n_a), 32'd1);
    step();
    chk("sel_busy_t3", 32'(busy), 32'd0);

    // FIRE 5
    issue(2'd2, 10'h000, 16'd5);
    for (int k = 1; k <= 5; k++) begin
      chk("f5_active", 32'(output_active_a), 32'd1);
      chk("f5_done_early", 32'(fire_done), 32'd0);
      chk("f5_ready", 32'(cmd_ready), 32'd0);
      step();
    end
    chk("f5_active_end", 32'(output_active_a), 32'd0);
    chk("f5_done", 32'(fire_done), 32'd1);
    chk("f5_idle", 32'(busy), 32'd0);
    step();
    chk("f5_done_single", 32'(fire_done), 32'd0);

    // FIRE 0
    issue(2'd2, 10'h000, 16'd0);
    chk("f0_done", 32'(fire_done), 32'd1);
    chk("f0_active", 32'(output_active_a), 32'd0);
    chk("f0_busy", 32'(busy), 32'd0);
    step();
    chk("f0_done_clear", 32'(fire_done), 32'd0);

    // FIRE 100, abort on the 10th active cycle
    issue(2'd2, 10'h000, 16'd100);
    for (int k = 1; k < 10; k++) step();
    chk("f100_active_t10", 32'(output_active_a), 32'd1);
    fire_abort = 1'b1;
    step();
    fire_abort = 1'b0;
    chk("abort_active", 32'(output_active_a), 32'd0);
    chk("abort_done", 32'(fire_done), 32'd1);
    chk("abort_idle", 32'(busy), 32'd0);
    step();
    chk("abort_done_single", 32'(fire_done), 32'd0);
    chk("abort_active_stays", 32'(output_active_a), 32'd0);

    // FIRE 3, abort on the last count cycle
    issue(2'd2, 10'h000, 16'd3);
    step();
    step();
    chk("f3_active_last", 32'(output_active_a), 32'd1);
    fire_abort = 1'b1;
    step();
    chk("f3_done", 32'(fire_done), 32'd1);
    chk("f3_active_end", 32'(output_active_a), 32'd0);
    // abort still held while idle must be ignored
    step();
    fire_abort = 1'b0;
    chk("f3_done_single", 32'(fire_done), 32'd0);
    chk("abort_idle_ignored", 32'(busy), 32'd0);

    // NOP: no busy, no field change
    issue(2'd3, 10'h3FF, 16'hFFFF);
    chk("nop_busy", 32'(busy), 32'd0);
    chk("nop_addr", 32'(mem_address_a), 32'h2A5);
    chk("nop_row", 32'(row_select_a), 32'd3);

    // Back-to-back WRITE, WRITE, SELECT with cmd_valid held
    idx = 0;
    cyc = 0;
    cmd_op = 2'd0; cmd_addr = 10'h111; cmd_data = 16'h1234;
    cmd_valid = 1'b1;
    while (idx < 3 && cyc < 60) begin
      if (cmd_ready) begin
        accept_cyc[idx] = cyc;
        idx++;
        step();
        cyc++;
        if (idx == 1) begin cmd_op = 2'd0; cmd_addr = 10'h222; cmd_data = 16'h5678; end
        if (idx == 2) begin cmd_op = 2'd1; cmd_addr = 10'h000; cmd_data = 16'h1FFF; end
        if (idx == 3) cmd_valid = 1'b0;
      end else begin
        step();
        cyc++;
      end
    end
    chk("b2b_all_accepted", 32'(idx), 32'd3);
    chk("b2b_gap1", 32'(accept_cyc[1] - accept_cyc[0]), 32'd9);
    chk("b2b_gap2", 32'(accept_cyc[2] - accept_cyc[1]), 32'd9);
    chk("b2b_addr", 32'(mem_address_a), 32'h222);
    chk("b2b_data", 32'(data_in_a), 32'h5678);
    chk("b2b_row", 32'(row_select_a), 32'd63);
    chk("b2b_col", 32'(col_select_a), 32'd63);
    chk("b2b_rcs", 32'(row_col_select_a), 32'd1);
    chk("b2b_inv", 32'(inverter_select_a), 32'd0);
    step();
    step();

    // Reset during STROBE
    issue(2'd0, 10'h155, 16'hA5A5);
    step();
    step();
    step();
    chk("mid_strobe_wn", 32'(mem_write_n_a), 32'd0);
    reset_n = 1'b0;
    #1;
    chk("arst_wn", 32'(mem_write_n_a), 32'd1);
    chk("arst_addr", 32'(mem_address_a), 32'd0);
    chk("arst_data", 32'(data_in_a), 32'd0);
    chk("arst_row", 32'(row_select_a), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    step();
    reset_n = 1'b1;
    step();
    chk("arst_ready", 32'(cmd_ready), 32'd1);
    chk("arst_wn_after", 32'(mem_write_n_a), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
